// File: rtl/ul_div_pkg.sv
// Shared types and sizing helpers for the divider-sharing arbiter.
// Holds the FSM state encoding, default widths and the timeout counter width.
package ul_div_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DIVIDEND_WIDTH = 22;
    localparam int DEF_DIVISOR_WIDTH  = 11;
    localparam int DEF_TIMEOUT        = 63;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Width of a counter that must reach max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Width of an index into n entries.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ul_rr_arb.sv
// Round-robin grant: the search starts at the entry after i_ptr and wraps,
// so the last winner has the lowest priority.
module ul_rr_arb
    import ul_div_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // NOTE: every variable written here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ul_div_arb.sv
// Shares one multi-cycle divider among NUM_REQ requesters, one request at a
// time, with divide-by-zero short-circuit and a WAIT timeout.
module ul_div_arb
    import ul_div_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DIVIDEND_WIDTH-1:0]           rsp_quotient,
    output logic [DIVISOR_WIDTH-1:0]            rsp_remainder,
    output logic                                rsp_err,
    output logic                                div_start,
    output logic [DIVIDEND_WIDTH-1:0]           div_dividend,
    output logic [DIVISOR_WIDTH-1:0]            div_divisor,
    input  logic                                div_busy,
    input  logic                                div_done,
    input  logic [DIVIDEND_WIDTH-1:0]           div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]            div_remainder
);

    localparam int                PTR_W    = idx_width(NUM_REQ);
    localparam int                CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                      r_state, w_next;
    logic [PTR_W-1:0]            r_ptr, r_id, w_gnt_idx;
    logic [NUM_REQ-1:0]          w_grant;
    logic                        w_take, w_div_zero, w_tmo;
    logic [DIVIDEND_WIDTH-1:0]   r_dividend, w_sel_dividend, r_rsp_q;
    logic [DIVISOR_WIDTH-1:0]    r_divisor, w_sel_divisor, r_rsp_r;
    logic                        r_rsp_err;
    logic [CNT_W-1:0]            r_cnt;

    ul_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    // Grants are gated by rst so req_ready reads 0 while reset is held.
    assign w_take     = !rst && (r_state == ST_IDLE) && (|req_valid) && !div_busy;
    assign w_div_zero = (r_divisor == '0);
    assign w_tmo      = (r_cnt == CNT_LAST);

    always_comb begin
        w_gnt_idx      = '0;
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx      = PTR_W'(i);
                w_sel_dividend = req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
                w_sel_divisor  = req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_take) w_next = ST_ISSUE;
            ST_ISSUE: w_next = w_div_zero ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (div_done || w_tmo) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= PTR_W'(NUM_REQ - 1);
            r_id       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_cnt      <= '0;
            r_rsp_q    <= '0;
            r_rsp_r    <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_ptr      <= w_gnt_idx;
                        r_id       <= w_gnt_idx;
                        r_dividend <= w_sel_dividend;
                        r_divisor  <= w_sel_divisor;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= '0;
                    if (w_div_zero) begin
                        r_rsp_q   <= '1;
                        r_rsp_r   <= '0;
                        r_rsp_err <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // A completion in the final WAIT cycle beats the timeout.
                    if (div_done) begin
                        r_rsp_q   <= div_quotient;
                        r_rsp_r   <= div_remainder;
                        r_rsp_err <= 1'b0;
                    end else if (w_tmo) begin
                        r_rsp_q   <= '0;
                        r_rsp_r   <= '0;
                        r_rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (r_state == ST_RESP) && (r_id == PTR_W'(i));
        end
    end

    assign req_ready     = w_take ? w_grant : '0;
    assign div_start     = (r_state == ST_ISSUE) && !w_div_zero;
    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign rsp_quotient  = r_rsp_q;
    assign rsp_remainder = r_rsp_r;
    assign rsp_err       = r_rsp_err;

endmodule

// File: tb/tb_ul_div_arb.sv
// Scoreboard bench for ul_div_arb: stimulus pushes expected responses at
// grant time, a monitor pops and compares whenever rsp_valid fires.
module tb_ul_div_arb;

    localparam int N       = 4;
    localparam int DW      = 22;
    localparam int SW      = 11;
    localparam int TMO     = 63;
    localparam int DIV_LAT = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready, rsp_valid;
    logic [N*DW-1:0]   req_dividend;
    logic [N*SW-1:0]   req_divisor;
    logic [DW-1:0]     rsp_quotient, div_dividend, div_quotient;
    logic [SW-1:0]     rsp_remainder, div_divisor, div_remainder;
    logic              rsp_err, div_start, div_busy, div_done;

    typedef struct {
        int          id;
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   starts   = 0;

    ul_div_arb #(
        .NUM_REQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
        .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_done(div_done),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Divider model: done one cycle, DIV_LAT cycles after start; withhold = never done.
    logic withhold;
    int   m_cnt;
    logic [DW-1:0] m_dvd;
    logic [SW-1:0] m_dvs;

    initial begin
        div_busy = 1'b0; div_done = 1'b0;
        div_quotient = '0; div_remainder = '0;
        m_cnt = 0; m_dvd = '0; m_dvs = '0;
    end

    always @(negedge clk) begin
        div_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                div_done      = 1'b1;
                div_busy      = 1'b0;
                div_quotient  = m_dvd / DW'(m_dvs);
                div_remainder = SW'(m_dvd % DW'(m_dvs));
            end
        end
        if (div_start) begin
            m_dvd    = div_dividend;
            m_dvs    = div_divisor;
            div_busy = 1'b1;
            m_cnt    = withhold ? 0 : DIV_LAT;
        end
    end

    // Monitor: compare each response against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            tick();
            if (div_start) starts++;
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid_bit", rsp_valid, 64'(1) << e.id);
                    check("rsp_quotient", rsp_quotient, e.q);
                    check("rsp_remainder", rsp_remainder, e.r);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic request(input int id, input logic [DW-1:0] dvd, input logic [SW-1:0] dvs,
                           input int lat, input logic [DW-1:0] eq, input logic [SW-1:0] er,
                           input logic eerr, input bit keep);
        exp_t e;
        bit   got = 1'b0;
        req_dividend[id*DW +: DW] = dvd;
        req_divisor[id*SW +: SW]  = dvs;
        req_valid[id] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("grant_seen", got, 1);
        if (got) begin
            check("req_ready_onehot", req_ready, 64'(1) << id);
            e.id = id; e.q = eq; e.r = er; e.err = eerr; e.cyc = cyc + lat;
            sb.push_back(e);
            grant_log.push_back(id);
            grant_cyc.push_back(cyc);
        end
        tick();
        if (!keep || !got) req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, base, bad, fell;
        rst = 1'b1; withhold = 1'b0;
        req_valid = '0; req_dividend = '0; req_divisor = '0;
        tick(); tick();
        req_valid = '1;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_quotient", rsp_quotient, 0);
        check("rst_rsp_remainder", rsp_remainder, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_div_start", div_start, 0);
        check("rst_div_operands", {div_dividend, div_divisor}, 0);
        req_valid = '0;
        tick();
        rst = 1'b0;
        tick();

        // All four at once: grant order 0,1,2,3.
        base = grant_log.size();
        fork
            request(0, 22'd4194303, 11'd2047, 13, 22'd2049, 11'd0,  1'b0, 1'b0);
            request(1, 22'd12345,   11'd100,  13, 22'd123,  11'd45, 1'b0, 1'b0);
            request(2, 22'd500,     11'd13,   13, 22'd38,   11'd6,  1'b0, 1'b0);
            request(3, 22'd99,      11'd100,  13, 22'd0,    11'd99, 1'b0, 1'b0);
        join
        drain();
        for (int i = 0; i < 4; i++) check("rr_order_after_reset", grant_log[base+i], i);

        // Single request and hold of response fields afterwards.
        request(0, 22'd1000, 11'd7, 13, 22'd142, 11'd6, 1'b0, 1'b0);
        drain();
        tick(); tick(); tick();
        check("hold_quotient", rsp_quotient, 142);
        check("hold_remainder", rsp_remainder, 6);
        check("hold_err", rsp_err, 0);

        // Divide by zero: no divider start, 2-cycle response.
        s0 = starts;
        request(2, 22'd555, 11'd0, 2, 22'h3FFFFF, 11'd0, 1'b1, 1'b0);
        drain();
        check("div0_no_start", starts - s0, 0);

        // Withheld done: timeout 64 cycles after start, then normal service.
        withhold = 1'b1;
        s0 = starts;
        request(1, 22'd20, 11'd3, TMO + 2, 22'd0, 11'd0, 1'b1, 1'b0);
        drain();
        check("timeout_single_start", starts - s0, 1);
        withhold = 1'b0;
        div_busy = 1'b0;
        request(1, 22'd20, 11'd3, 13, 22'd6, 11'd2, 1'b0, 1'b0);
        drain();

        // Reset in WAIT while the divider stays busy.
        request(0, 22'd100, 11'd9, 13, 22'd11, 11'd1, 1'b0, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_wait_rsp_fields", {rsp_quotient, rsp_remainder, rsp_err}, 0);
        check("rst_wait_div_operands", {div_dividend, div_divisor}, 0);
        check("rst_wait_div_start", div_start, 0);
        rst = 1'b0;
        sb.delete();
        bad = 0; fell = -1;
        fork
            request(1, 22'd77, 11'd7, 13, 22'd11, 11'd0, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 40; k++) begin
                    if (!div_busy) begin
                        fell = cyc;
                        break;
                    end
                    if (req_ready != '0 || rsp_valid != '0) bad++;
                    tick();
                end
            end
        join
        check("busy_blocks_grant", bad, 0);
        check("busy_fell_seen", fell >= 0, 1);
        check("grant_at_busy_fall", grant_cyc[$], fell);
        drain();

        // Requester 1 held valid; requester 3 must get in within one round.
        base = grant_log.size();
        fork
            begin
                request(1, 22'd60, 11'd7, 13, 22'd8, 11'd4, 1'b0, 1'b1);
                request(1, 22'd61, 11'd7, 13, 22'd8, 11'd5, 1'b0, 1'b1);
                request(1, 22'd62, 11'd7, 13, 22'd8, 11'd6, 1'b0, 1'b0);
            end
            begin
                for (int k = 0; k < 100; k++) begin
                    if (grant_log.size() > base) break;
                    tick();
                end
                check("req1_first_grant", grant_log.size() > base, 1);
                request(3, 22'd300, 11'd17, 13, 22'd17, 11'd11, 1'b0, 1'b0);
            end
        join
        drain();
        check("fair_grant0", grant_log[base],   1);
        check("fair_grant1", grant_log[base+1], 3);
        check("fair_grant2", grant_log[base+2], 1);

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
